// File: rtl/ladybird_lsu_issue.sv
// Load/store issue queue in front of ladybird_lsu.
// Buffers execute-stage memory requests and drops misaligned ones with a one-cycle report.
// Limits how many requests can be outstanding at the LSU, and holds a FENCE until the LSU drains.
// Each LSU response is matched to its destination register to produce the load writeback.
module ladybird_lsu_issue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned XLEN            = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_we,
    input  logic [2:0]      i_funct,
    input  logic            i_fence,
    input  logic [4:0]      i_rd,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_addr,
    output logic            lsu_valid,
    input  logic            lsu_ready,
    output logic [XLEN-1:0] lsu_addr,
    output logic [XLEN-1:0] lsu_data,
    output logic            lsu_we,
    output logic [2:0]      lsu_funct,
    output logic            lsu_fence,
    input  logic            lsu_rvalid,
    input  logic [XLEN-1:0] lsu_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            we;
        logic [2:0]      funct;
        logic            fence;
        logic [4:0]      rd;
    } req_t;

    typedef struct packed {
        logic       is_load;
        logic [4:0] rd;
    } tag_t;

    req_t            mem_q [DEPTH];
    req_t            mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    tag_t            tag_q [MAX_OUTSTANDING];
    tag_t            tag_d [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TW-1:0]   tag_rd_ptr_q, tag_rd_ptr_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;

    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            accept;
    logic            misaligned;
    logic            push;
    logic            issue;
    logic            rsp;
    logic            empty;
    req_t            head;
    tag_t            rsp_tag;

    // Handshake decode, misalignment check and issue gating.
    always_comb begin
        empty      = (count_q == '0);
        i_ready    = (count_q != CW'(DEPTH));
        accept     = i_valid & i_ready;
        misaligned = !i_fence &&
                     (((i_funct[1:0] == 2'd1) && i_addr[0]) ||
                      ((i_funct[1:0] == 2'd2) && (i_addr[1:0] != 2'b00)));
        push       = accept & !misaligned;
        head       = mem_q[rd_ptr_q];
        // A fence may only leave once everything ahead of it has responded.
        lsu_valid  = !empty && (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                     (!head.fence || (outstanding_q == '0));
        issue      = lsu_valid & lsu_ready;
        // Stray responses with nothing outstanding are dropped.
        rsp        = lsu_rvalid && (outstanding_q != '0);
        rsp_tag    = tag_q[tag_rd_ptr_q];
        lsu_addr   = lsu_valid ? head.addr  : '0;
        lsu_data   = lsu_valid ? head.data  : '0;
        lsu_we     = lsu_valid ? head.we    : 1'b0;
        lsu_funct  = lsu_valid ? head.funct : 3'd0;
        lsu_fence  = lsu_valid ? head.fence : 1'b0;
        o_busy     = (count_q != '0) || (outstanding_q != '0);
    end

    // Next-state for the request FIFO, tag FIFO, counters and registered outputs.
    always_comb begin
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        tag_d           = tag_q;
        tag_wr_ptr_d    = tag_wr_ptr_q;
        tag_rd_ptr_d    = tag_rd_ptr_q;
        outstanding_d   = outstanding_q;
        misalign_d      = accept & misaligned;
        misalign_addr_d = misalign_q ? misalign_addr_q : '0;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;

        if (accept && misaligned) begin
            misalign_addr_d = i_addr;
        end else if (!misalign_q) begin
            misalign_addr_d = '0;
        end else begin
            misalign_addr_d = misalign_addr_q;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{addr: i_addr, data: i_data, we: i_we, funct: i_funct,
                                fence: i_fence, rd: i_rd};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d               = rd_ptr_q + 1'b1;
            tag_d[tag_wr_ptr_q]    = '{is_load: !head.we && !head.fence, rd: head.rd};
            tag_wr_ptr_d           = (tag_wr_ptr_q == TW'(MAX_OUTSTANDING - 1)) ?
                                     '0 : tag_wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(issue);

        if (rsp) begin
            tag_rd_ptr_d = (tag_rd_ptr_q == TW'(MAX_OUTSTANDING - 1)) ?
                           '0 : tag_rd_ptr_q + 1'b1;
            if (rsp_tag.is_load && (rsp_tag.rd != 5'd0)) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rsp_tag.rd;
                wb_data_d  = lsu_rdata;
            end
        end
        outstanding_d = outstanding_q + OW'(issue) - OW'(rsp);
    end

    // Control state, counters and registered outputs; all cleared by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tag_wr_ptr_q    <= '0;
            tag_rd_ptr_q    <= '0;
            outstanding_q   <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            tag_wr_ptr_q    <= tag_wr_ptr_d;
            tag_rd_ptr_q    <= tag_rd_ptr_d;
            outstanding_q   <= outstanding_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
        end
    end

    // Payload storage; contents are only observed through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        tag_q <= tag_d;
    end

    assign o_misalign      = misalign_q;
    assign o_misalign_addr = misalign_addr_q;
    assign o_wb_valid      = wb_valid_q;
    assign o_wb_rd         = wb_rd_q;
    assign o_wb_data       = wb_data_q;

    // A response with nothing outstanding means the LSU broke its protocol.
    rvalid_without_outstanding_a: assert property (
        @(posedge clk) disable iff (!nrst) !(lsu_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_ladybird_lsu_issue.sv
// Directed bench for ladybird_lsu_issue (DEPTH=4, MAX_OUTSTANDING=2, XLEN=32).
module tb_ladybird_lsu_issue;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_we;
    logic [2:0]  i_funct;
    logic        i_fence;
    logic [4:0]  i_rd;
    logic        o_misalign;
    logic [31:0] o_misalign_addr;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_data;
    logic        lsu_we;
    logic [2:0]  lsu_funct;
    logic        lsu_fence;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ladybird_lsu_issue #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .XLEN           (32)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_addr         (i_addr),
        .i_data         (i_data),
        .i_we           (i_we),
        .i_funct        (i_funct),
        .i_fence        (i_fence),
        .i_rd           (i_rd),
        .o_misalign     (o_misalign),
        .o_misalign_addr(o_misalign_addr),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_addr       (lsu_addr),
        .lsu_data       (lsu_data),
        .lsu_we         (lsu_we),
        .lsu_funct      (lsu_funct),
        .lsu_fence      (lsu_fence),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rdata      (lsu_rdata),
        .o_wb_valid     (o_wb_valid),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] data, input logic we,
                       input logic [2:0] funct, input logic fence, input logic [4:0] rd);
        i_valid = 1'b1;
        i_addr  = addr;
        i_data  = data;
        i_we    = we;
        i_funct = funct;
        i_fence = fence;
        i_rd    = rd;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_addr  = '0;
        i_data  = '0;
        i_we    = 1'b0;
        i_funct = '0;
        i_fence = 1'b0;
        i_rd    = '0;
    endtask

    initial begin
        nrst       = 1'b0;
        lsu_ready  = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        idle();

        // Reset state
        #1;
        check("rst_i_ready", 32'(i_ready), 32'd1);
        check("rst_lsu_valid", 32'(lsu_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        check("rst_misalign", 32'(o_misalign), 32'd0);
        check("rst_lsu_addr", lsu_addr, 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();

        // 1: single LW, response two cycles after issue
        lsu_ready = 1'b1;
        req(32'h100, 32'h0, 1'b0, 3'd2, 1'b0, 5'd5);
        #1;
        check("t1_valid_same_cycle", 32'(lsu_valid), 32'd0);
        tick();
        idle();
        #1;
        check("t1_lsu_valid", 32'(lsu_valid), 32'd1);
        check("t1_lsu_addr", lsu_addr, 32'h100);
        check("t1_lsu_funct", 32'(lsu_funct), 32'd2);
        check("t1_lsu_we", 32'(lsu_we), 32'd0);
        check("t1_busy", 32'(o_busy), 32'd1);
        tick();
        #1;
        check("t1_valid_after_issue", 32'(lsu_valid), 32'd0);
        tick();
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hDEADBEEF;
        #1;
        check("t1_wb_early", 32'(o_wb_valid), 32'd0);
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t1_wb_valid", 32'(o_wb_valid), 32'd1);
        check("t1_wb_rd", 32'(o_wb_rd), 32'd5);
        check("t1_wb_data", o_wb_data, 32'hDEADBEEF);
        check("t1_busy_done", 32'(o_busy), 32'd0);
        tick();
        #1;
        check("t1_wb_pulse", 32'(o_wb_valid), 32'd0);

        // 2: misaligned LH and SW are dropped
        req(32'h101, 32'h0, 1'b0, 3'd1, 1'b0, 5'd3);
        tick();
        req(32'h202, 32'h55, 1'b1, 3'd2, 1'b0, 5'd0);
        #1;
        check("t2_mis1", 32'(o_misalign), 32'd1);
        check("t2_mis1_addr", o_misalign_addr, 32'h101);
        check("t2_lsu_valid1", 32'(lsu_valid), 32'd0);
        tick();
        idle();
        #1;
        check("t2_mis2", 32'(o_misalign), 32'd1);
        check("t2_mis2_addr", o_misalign_addr, 32'h202);
        check("t2_lsu_valid2", 32'(lsu_valid), 32'd0);
        check("t2_busy", 32'(o_busy), 32'd0);
        tick();
        #1;
        check("t2_mis_pulse", 32'(o_misalign), 32'd0);

        // 3: fill to DEPTH with LSU stalled, then drain in order
        lsu_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            req(32'(k * 16), 32'h0, 1'b0, 3'd2, 1'b0, 5'(k));
            #1;
            check($sformatf("t3_ready_%0d", k), 32'(i_ready), 32'd1);
            tick();
        end
        req(32'h50, 32'h0, 1'b0, 3'd2, 1'b0, 5'd5);
        #1;
        check("t3_full", 32'(i_ready), 32'd0);
        check("t3_head_valid", 32'(lsu_valid), 32'd1);
        check("t3_head_addr", lsu_addr, 32'h10);
        tick();
        #1;
        check("t3_head_stable", lsu_addr, 32'h10);
        check("t3_still_full", 32'(i_ready), 32'd0);
        lsu_ready = 1'b1;
        tick();
        #1;
        check("t3_ready_after_pop", 32'(i_ready), 32'd1);
        check("t3_issue2_addr", lsu_addr, 32'h20);
        tick();
        idle();
        for (int s = 0; s < 5; s++) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = 32'hA1 + 32'(s);
            #1;
            check($sformatf("t3_valid_s%0d", s), 32'(lsu_valid), 32'((s >= 1) && (s <= 3)));
            if ((s >= 1) && (s <= 3)) begin
                check($sformatf("t3_addr_s%0d", s), lsu_addr, 32'((s + 2) * 16));
            end
            check($sformatf("t3_wbv_s%0d", s), 32'(o_wb_valid), 32'(s >= 1));
            if (s >= 1) begin
                check($sformatf("t3_wbrd_s%0d", s), 32'(o_wb_rd), 32'(s));
                check($sformatf("t3_wbdata_s%0d", s), o_wb_data, 32'hA0 + 32'(s));
            end
            tick();
        end
        lsu_rvalid = 1'b0;
        #1;
        check("t3_wbrd_last", 32'(o_wb_rd), 32'd5);
        check("t3_wbdata_last", o_wb_data, 32'hA5);
        check("t3_busy_done", 32'(o_busy), 32'd0);

        // 4: outstanding limit of two
        req(32'h400, 32'h0, 1'b0, 3'd2, 1'b0, 5'd6);
        tick();
        req(32'h404, 32'h0, 1'b0, 3'd2, 1'b0, 5'd7);
        #1;
        check("t4_issue1", lsu_addr, 32'h400);
        tick();
        req(32'h408, 32'h0, 1'b0, 3'd2, 1'b0, 5'd8);
        #1;
        check("t4_issue2", lsu_addr, 32'h404);
        tick();
        idle();
        #1;
        check("t4_held_a", 32'(lsu_valid), 32'd0);
        tick();
        #1;
        check("t4_held_b", 32'(lsu_valid), 32'd0);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h61;
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t4_third_valid", 32'(lsu_valid), 32'd1);
        check("t4_third_addr", lsu_addr, 32'h408);
        check("t4_wb_rd6", 32'(o_wb_rd), 32'd6);
        tick();
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h62;
        tick();
        lsu_rdata = 32'h63;
        #1;
        check("t4_wb_rd7", 32'(o_wb_rd), 32'd7);
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t4_wb_rd8", 32'(o_wb_rd), 32'd8);
        check("t4_wb_data8", o_wb_data, 32'h63);
        check("t4_busy_done", 32'(o_busy), 32'd0);

        // 5: SW, FENCE, LW with a slow SW response
        req(32'h500, 32'h1234, 1'b1, 3'd2, 1'b0, 5'd0);
        tick();
        req(32'h3, 32'h0, 1'b0, 3'd2, 1'b1, 5'd0);
        #1;
        check("t5_sw_we", 32'(lsu_we), 32'd1);
        check("t5_sw_data", lsu_data, 32'h1234);
        tick();
        req(32'h600, 32'h0, 1'b0, 3'd2, 1'b0, 5'd9);
        #1;
        check("t5_fence_held", 32'(lsu_valid), 32'd0);
        tick();
        idle();
        #1;
        check("t5_fence_not_misaligned", 32'(o_misalign), 32'd0);
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("t5_wait_%0d", i), 32'(lsu_valid), 32'd0);
            tick();
        end
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hBAD;
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t5_sw_no_wb", 32'(o_wb_valid), 32'd0);
        check("t5_fence_valid", 32'(lsu_valid), 32'd1);
        check("t5_fence_flag", 32'(lsu_fence), 32'd1);
        tick();
        lsu_ready  = 1'b0;
        lsu_rvalid = 1'b1;
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t5_fence_no_wb", 32'(o_wb_valid), 32'd0);
        check("t5_lw_valid", 32'(lsu_valid), 32'd1);
        check("t5_lw_addr", lsu_addr, 32'h600);
        check("t5_lw_not_fence", 32'(lsu_fence), 32'd0);
        lsu_ready = 1'b1;
        tick();
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h77;
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t5_lw_wb_rd", 32'(o_wb_rd), 32'd9);
        check("t5_lw_wb_data", o_wb_data, 32'h77);
        check("t5_busy_done", 32'(o_busy), 32'd0);

        // 6: LW to x0 produces no writeback; reset discards queued work
        req(32'h700, 32'h0, 1'b0, 3'd2, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h99;
        tick();
        lsu_rvalid = 1'b0;
        #1;
        check("t6_x0_no_wb", 32'(o_wb_valid), 32'd0);
        lsu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req(32'h800 + 32'(k * 4), 32'h0, 1'b0, 3'd2, 1'b0, 5'd10);
            tick();
        end
        idle();
        #1;
        check("t6_busy_before", 32'(o_busy), 32'd1);
        check("t6_valid_before", 32'(lsu_valid), 32'd1);
        nrst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(i_ready), 32'd1);
        check("t6_rst_valid", 32'(lsu_valid), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        tick();
        nrst = 1'b1;
        tick();
        #1;
        check("t6_post_valid", 32'(lsu_valid), 32'd0);
        check("t6_post_busy", 32'(o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
